// File: rtl/rmw_pkg.sv
// Shared definitions for the read-modify-write sequencer: ALU opcodes,
// FSM state encoding and opcode classification helpers.
package rmw_pkg;

    localparam int unsigned OPC_W  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ST_W   = 3;

    // ALU opcodes shared with the ALU and the instruction decoder
    localparam logic [OPC_W-1:0] OP_INC = 4'd5;
    localparam logic [OPC_W-1:0] OP_DEC = 4'd6;
    localparam logic [OPC_W-1:0] OP_ROR = 4'd7;
    localparam logic [OPC_W-1:0] OP_ROL = 4'd8;
    localparam logic [OPC_W-1:0] OP_ASL = 4'd9;
    localparam logic [OPC_W-1:0] OP_LSR = 4'd10;

    // Sequencer states
    typedef logic [ST_W-1:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_READ  = 3'd1;
    localparam state_t ST_DUMMY = 3'd2;
    localparam state_t ST_WRITE = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // Opcode is one of the six memory RMW operations
    function automatic logic is_legal_op(input logic [OPC_W-1:0] o);
        return (o >= OP_INC) && (o <= OP_LSR);
    endfunction

    // Shift/rotate ops are the ones that produce a new carry
    function automatic logic is_shift_op(input logic [OPC_W-1:0] o);
        return (o >= OP_ROR) && (o <= OP_LSR);
    endfunction

endpackage

// File: rtl/rmw_sequencer.sv
// Read-modify-write sequencer for 6502-style memory instructions.
// Runs bus order: read -> dummy write of original -> write of modified value.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   start, op, addr, c_in            command from decoder (sampled in IDLE)
//   busy, done, err                  status (done/err are one-cycle pulses)
//   mem_addr, mem_we, mem_wdata      bus request
//   mem_rdata, mem_rdy               bus response
//   alu_op, alu_a, alu_b, alu_cin    ALU drive
//   alu_f, alu_carry                 ALU result
//   result, flag_n/z/c, flags_we,
//   flags_c_we                       write-back to status register
module rmw_sequencer
    import rmw_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OPC_W-1:0]  op,
    input  logic [ADDR_W-1:0] addr,
    input  logic              c_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic [OPC_W-1:0]  alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_cin,
    input  logic [DATA_W:0]   alu_f,
    input  logic              alu_carry,
    output logic [DATA_W-1:0] result,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flags_we,
    output logic              flags_c_we
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   operand_q, operand_d;
    logic [DATA_W-1:0]   new_val_q, new_val_d;
    logic                new_c_q, new_c_d;

    logic                busy_d, done_d, err_d, we_d, cin_d;
    logic                fn_d, fz_d, fc_d, fwe_d, fcwe_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d, result_d;
    logic [OPC_W-1:0]    op_d;

    // Bit 8 of the ALU result duplicates alu_carry
    logic alu_f_unused;
    assign alu_f_unused = alu_f[DATA_W];

    // Both ALU operands carry the fetched byte
    assign alu_a = operand_q;
    assign alu_b = operand_q;

    // Next-state and next-output logic; outputs are computed one cycle ahead
    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        new_val_d = new_val_q;
        new_c_d   = new_c_q;
        busy_d    = busy;
        done_d    = 1'b0;
        err_d     = 1'b0;
        we_d      = mem_we;
        addr_d    = mem_addr;
        wdata_d   = mem_wdata;
        op_d      = alu_op;
        cin_d     = alu_cin;
        result_d  = result;
        fn_d      = flag_n;
        fz_d      = flag_z;
        fc_d      = flag_c;
        fwe_d     = 1'b0;
        fcwe_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_legal_op(op)) begin
                        op_d    = op;
                        addr_d  = addr;
                        cin_d   = c_in;
                        we_d    = 1'b0;
                        busy_d  = 1'b1;
                        state_d = ST_READ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (mem_rdy) begin
                    operand_d = mem_rdata;
                    wdata_d   = mem_rdata;
                    we_d      = 1'b1;
                    state_d   = ST_DUMMY;
                end
            end
            ST_DUMMY: begin
                if (mem_rdy) begin
                    new_val_d = alu_f[DATA_W-1:0];
                    new_c_d   = alu_carry;
                    wdata_d   = alu_f[DATA_W-1:0];
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mem_rdy) begin
                    we_d     = 1'b0;
                    result_d = new_val_q;
                    fn_d     = new_val_q[DATA_W-1];
                    fz_d     = (new_val_q == '0);
                    fc_d     = new_c_q;
                    done_d   = 1'b1;
                    fwe_d    = 1'b1;
                    fcwe_d   = is_shift_op(alu_op);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                we_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any RMW in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            operand_q  <= '0;
            new_val_q  <= '0;
            new_c_q    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            alu_op     <= '0;
            alu_cin    <= 1'b0;
            result     <= '0;
            flag_n     <= 1'b0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            flags_we   <= 1'b0;
            flags_c_we <= 1'b0;
        end else begin
            state_q    <= state_d;
            operand_q  <= operand_d;
            new_val_q  <= new_val_d;
            new_c_q    <= new_c_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
            mem_we     <= we_d;
            mem_addr   <= addr_d;
            mem_wdata  <= wdata_d;
            alu_op     <= op_d;
            alu_cin    <= cin_d;
            result     <= result_d;
            flag_n     <= fn_d;
            flag_z     <= fz_d;
            flag_c     <= fc_d;
            flags_we   <= fwe_d;
            flags_c_we <= fcwe_d;
        end
    end

endmodule

// File: tb/tb_rmw_sequencer.sv
// Directed self-checking bench for rmw_sequencer with a bus-event scoreboard.
module tb_rmw_sequencer;
    import rmw_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic [15:0] addr = '0;
    logic        c_in = 1'b0;
    logic        busy, done, err;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_rdy = 1'b0;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a, alu_b;
    logic        alu_cin;
    logic [8:0]  alu_f;
    logic        alu_carry;
    logic [7:0]  result;
    logic        flag_n, flag_z, flag_c, flags_we, flags_c_we;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;
    ev_t exp_q[$];

    rmw_sequencer #(.ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .addr(addr), .c_in(c_in),
        .busy(busy), .done(done), .err(err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_f(alu_f), .alu_carry(alu_carry),
        .result(result), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c),
        .flags_we(flags_we), .flags_c_we(flags_c_we)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: carry passes through for inc/dec
    always_comb begin
        logic [7:0] f;
        logic       c;
        f = 8'h00;
        c = alu_cin;
        case (alu_op)
            4'd5:  f = alu_a + 8'd1;
            4'd6:  f = alu_a - 8'd1;
            4'd7:  begin f = {alu_cin, alu_a[7:1]}; c = alu_a[0]; end
            4'd8:  begin f = {alu_a[6:0], alu_cin}; c = alu_a[7]; end
            4'd9:  begin f = {alu_a[6:0], 1'b0};    c = alu_a[7]; end
            4'd10: begin f = {1'b0, alu_a[7:1]};    c = alu_a[0]; end
            default: begin f = 8'h00; c = 1'b0; end
        endcase
        alu_f     = {c, f};
        alu_carry = c;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
        end
    endtask

    // One command with a fixed stall count per bus phase
    task automatic run_cmd(input logic [3:0] o, input logic [15:0] a, input logic ci,
                           input logic [7:0] d, input int stall,
                           input logic [7:0] er, input logic en, input logic ez,
                           input logic ec, input logic ecwe, input int edone,
                           input bit poke);
        int  cyc;
        int  lowcnt;
        bit  seen_done;
        ev_t ev;
        exp_q.push_back('{we: 1'b0, addr: a, data: d});
        exp_q.push_back('{we: 1'b1, addr: a, data: d});
        exp_q.push_back('{we: 1'b1, addr: a, data: er});
        @(negedge clk);
        start = 1'b1; op = o; addr = a; c_in = ci; mem_rdy = 1'b0; mem_rdata = d;
        cyc = 0; lowcnt = 0; seen_done = 1'b0;
        while (!seen_done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            mem_rdy = 1'b0;
            if (poke && cyc == 2) begin
                start = 1'b1; op = OP_ASL; addr = 16'h1234; c_in = ~ci;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen_done = 1'b1;
                chk("done_cycle", 32'(cyc), 32'(edone));
                chk("busy_in_done", 32'(busy), 32'd1);
                chk("flags_we", 32'(flags_we), 32'd1);
                chk("flags_c_we", 32'(flags_c_we), 32'(ecwe));
                chk("result", 32'(result), 32'(er));
                chk("flag_n", 32'(flag_n), 32'(en));
                chk("flag_z", 32'(flag_z), 32'(ez));
                if (ecwe) chk("flag_c", 32'(flag_c), 32'(ec));
                chk("we_in_done", 32'(mem_we), 32'd0);
            end else if (busy) begin
                chk("addr_stable", 32'(mem_addr), 32'(a));
                if (lowcnt < stall) begin
                    lowcnt++;
                end else begin
                    lowcnt = 0;
                    mem_rdy = 1'b1;
                    if (exp_q.size() == 0) begin
                        chk("bus_extra", 32'd1, 32'd0);
                    end else begin
                        ev = exp_q.pop_front();
                        chk("bus_we", 32'(mem_we), 32'(ev.we));
                        if (ev.we) chk("bus_wdata", 32'(mem_wdata), 32'(ev.data));
                    end
                end
            end
        end
        chk("done_seen", 32'(seen_done), 32'd1);
        chk("bus_remaining", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_after", 32'(done), 32'd0);
        chk("fwe_after", 32'(flags_we), 32'd0);
        chk("result_held", 32'(result), 32'(er));
    endtask

    initial begin
        // reset values
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_aluop", 32'(alu_op), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'({flag_n, flag_z, flag_c, flags_we, flags_c_we}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //      op      addr      ci    data   st res    n     z     c     cwe  done poke
        run_cmd(OP_INC, 16'h0200, 1'b0, 8'h7F, 0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b1);
        run_cmd(OP_ASL, 16'h0300, 1'b0, 8'h81, 0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b0);
        run_cmd(OP_ROR, 16'h0400, 1'b1, 8'h01, 2, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 10, 1'b0);
        run_cmd(OP_DEC, 16'h0010, 1'b0, 8'h00, 0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b0);
        run_cmd(OP_LSR, 16'hFFFF, 1'b0, 8'h01, 0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 4, 1'b0);
        run_cmd(OP_INC, 16'h8000, 1'b1, 8'hFF, 1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 7, 1'b0);
        run_cmd(OP_ROL, 16'h0123, 1'b1, 8'h40, 0, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 4, 1'b0);

        // illegal op: err pulse, no bus activity
        @(negedge clk);
        start = 1'b1; op = 4'd3; addr = 16'h0555;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        chk("err_clear", 32'(err), 32'd0);
        chk("err_busy2", 32'(busy), 32'd0);

        // reset during DUMMY abandons the operation
        @(negedge clk);
        start = 1'b1; op = OP_INC; addr = 16'h0500; c_in = 1'b0; mem_rdata = 8'h10;
        @(negedge clk);
        start = 1'b0; mem_rdy = 1'b1;
        @(negedge clk);
        mem_rdy = 1'b0;
        chk("pre_rst_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we", 32'(mem_we), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(OP_INC, 16'h0600, 1'b0, 8'h10, 0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rmw_sequencer.md
# rmw_sequencer

Multi-cycle controller that sequences the 8-bit ALU through 6502-style read-modify-write memory instructions (INC, DEC, ASL, LSR, ROL, ROR on memory operands). It accepts one command from the instruction decoder and runs the bus cycle order read → dummy write of the original value → write of the modified value. It drives the ALU opcode and operands, and returns the result plus N/Z/C flag updates to the status register. It sits between the decode/control unit, the shared ALU and the memory bus interface.

## Interface
- ADDR_W, 16, memory address width
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command valid; sampled only in IDLE
- op  in  4  ALU opcode: 5 inc, 6 dec, 7 ror, 8 rol, 9 asl, 10 lsr
- addr  in  ADDR_W  operand address, captured with start
- c_in  in  1  current carry flag, captured with start
- busy  out  1  high while a command is in progress
- done  out  1  one-cycle pulse when the command completes
- err  out  1  one-cycle pulse when start carries an illegal op
- mem_addr  out  ADDR_W  bus address
- mem_we  out  1  bus write strobe
- mem_wdata  out  8  bus write data
- mem_rdata  in  8  bus read data, valid when mem_rdy
- mem_rdy  in  1  bus cycle completes this clock
- alu_op  out  4  opcode to ALU
- alu_a, alu_b  out  8  ALU operands; both carry the fetched byte
- alu_cin  out  1  captured carry
- alu_f  in  9  ALU result
- alu_carry  in  1  ALU carry out
- result  out  8  final written value, held until the next command
- flag_n, flag_z, flag_c  out  1  flag values for the status register
- flags_we  out  1  pulse with done; flag_c is meaningful only if flags_c_we
- flags_c_we  out  1  high with flags_we for ops 7–10

## Operation
- States: IDLE, READ, DUMMY, WRITE, DONE.
- IDLE:
  - start with a legal op: latch op, addr and c_in, then go to READ.
  - start with an illegal op: pulse err next cycle and stay in IDLE.
- READ: mem_addr=addr, mem_we=0. On mem_rdy, latch mem_rdata into the operand register and go to DUMMY.
- DUMMY: mem_we=1, mem_wdata=operand. The ALU is evaluated combinationally from the operand. On mem_rdy, latch alu_f[7:0] into new_val and alu_carry into new_c, then go to WRITE.
- WRITE: mem_we=1, mem_wdata=new_val. On mem_rdy, go to DONE.
- DONE: done=1 and flags_we=1 for one cycle, then return to IDLE.
  - flag_n = new_val[7]; flag_z = (new_val==0); flag_c = new_c.
- For ops 5/6 the ALU passes carry through; flags_c_we=0.
- Wrap-around is mod 256: inc of 0xFF gives 0x00 with Z=1; dec of 0x00 gives 0xFF with N=1.
- start while busy is ignored; no queueing.
- Reset (async, mid-operation included) clears state to IDLE and drops mem_we the same instant. A partially completed RMW is abandoned.

## Timing
- Reset values: busy=0, done=0, err=0, mem_we=0, mem_addr=0, mem_wdata=0, alu_op=0, result=0, all flag outputs 0, flags_we=0, flags_c_we=0.
- busy rises the cycle after start is accepted and falls in the cycle after DONE.
- With mem_rdy held high: start accepted at cycle 0; READ at 1, DUMMY at 2, WRITE at 3, done at 4. Minimum latency is 4 cycles.
- Each mem_rdy=0 cycle stretches the current state by one cycle. Outputs stay stable while waiting.
- mem_addr is held at addr through READ, DUMMY and WRITE.
- result updates on entry to DONE.

## Structure
- Shared package rmw_pkg holds:
  - the ALU opcode constants (OP_INC=5 … OP_LSR=10), shared with the ALU and the decoder;
  - the state enum;
  - the legal-op check function.
- No sub-module; a single FSM plus datapath registers.

## Test plan
- INC at 0x0200 holding 0x7F, rdy always 1 → bus sequence R 0x7F, W 0x7F, W 0x80; done at cycle 4; N=1, Z=0, flags_c_we=0.
- ASL with c_in=0 on 0x81 → writes 0x81 then 0x02; C=1, N=0, Z=0, flags_c_we=1.
- ROR with c_in=1 on 0x01 with mem_rdy low 2 cycles in each state → writes 0x01 then 0x80; C=1, N=1; done at cycle 10; mem_addr stable throughout.
- DEC on 0x00 → result 0xFF, N=1, Z=0. Then LSR on 0x01 → result 0x00, Z=1, C=1.
- op=3 with start → err pulse, busy stays 0, no bus activity. A start during busy is ignored.
- rst_n asserted during DUMMY → mem_we=0 immediately and state IDLE; a new INC after release completes normally.
